// File: rtl/mem_stage_sram_pkg.sv
// Shared definitions for the memory stage: FSM states, default parameters and constants.
package mem_stage_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } mem_state_e;

  localparam int unsigned BASE_ADDR_DEF = 1024;
  localparam int unsigned TIMEOUT_DEF   = 255;
  localparam logic [31:0] LOAD_ERR_DATA = 32'hDEADBEEF;

  // Byte offset of an execute-stage address from the start of data memory (wraps).
  function automatic logic [31:0] byte_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/mem_stage_sram_mem_wb.sv
// MEM/WB pipeline register: loads a new instruction, inserts a bubble, or holds.
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic        data_load_i,
  input  logic        wb_en_i,
  input  logic        mem_r_en_i,
  input  logic [3:0]  dest_i,
  input  logic [31:0] alu_res_i,
  input  logic [31:0] mem_data_i,
  output logic        wb_en_o,
  output logic        mem_r_en_o,
  output logic [3:0]  dest_o,
  output logic [31:0] alu_res_o,
  output logic [31:0] mem_data_o
);

  logic        wb_en_q, wb_en_d;
  logic        mem_r_en_q, mem_r_en_d;
  logic [3:0]  dest_q, dest_d;
  logic [31:0] alu_res_q, alu_res_d;
  logic [31:0] mem_data_q, mem_data_d;

  // Bubble clears only the control bits; payload fields keep their last value.
  always_comb begin
    wb_en_d    = wb_en_q;
    mem_r_en_d = mem_r_en_q;
    dest_d     = dest_q;
    alu_res_d  = alu_res_q;
    mem_data_d = mem_data_q;
    if (bubble_i) begin
      wb_en_d    = 1'b0;
      mem_r_en_d = 1'b0;
    end else if (load_i) begin
      wb_en_d    = wb_en_i;
      mem_r_en_d = mem_r_en_i;
      dest_d     = dest_i;
      alu_res_d  = alu_res_i;
      if (data_load_i) begin
        mem_data_d = mem_data_i;
      end
    end
  end

  // Register state with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      dest_q     <= '0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
    end else begin
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      dest_q     <= dest_d;
      alu_res_q  <= alu_res_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign wb_en_o    = wb_en_q;
  assign mem_r_en_o = mem_r_en_q;
  assign dest_o     = dest_q;
  assign alu_res_o  = alu_res_q;
  assign mem_data_o = mem_data_q;

endmodule

// File: rtl/mem_stage_sram.sv
// Memory stage: req/ack data-memory master, upstream freeze and the MEM/WB register.
// Optional bus timeout is enabled with the MEM_TIMEOUT_EN macro.
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int unsigned BASE_ADDR = BASE_ADDR_DEF,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              wb_en_in,
  input  logic [3:0]        dest_in,
  input  logic [31:0]       alu_res_in,
  input  logic [31:0]       val_rm_in,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack,
  output logic              freeze,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [3:0]        dest_out,
  output logic [31:0]       alu_res_out,
  output logic [31:0]       mem_data_out,
  output logic              mem_err
);

  mem_state_e state_q, state_d;

  logic              launch;
  logic              ack_take;
  logic              tmo;

  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_we_q, bus_we_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [31:0]       data_q, data_d;

  logic [31:0]       byte_off;
  logic [ADDR_W-1:0] word_addr;
  logic              unused_addr_bits;

  // Word address: drop the byte lane bits, keep ADDR_W bits, no range check.
  assign byte_off         = byte_offset(alu_res_in, 32'(BASE_ADDR));
  assign word_addr        = byte_off[ADDR_W+1:2];
  assign unused_addr_bits = ^{byte_off[31:ADDR_W+2], byte_off[1:0]};

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CNT_W-1:0] wait_q, wait_d;
  logic             mem_err_q;

  // Wait counter: cleared on ACCESS entry, counts ACCESS cycles without ack.
  always_comb begin
    wait_d = wait_q;
    if (launch) begin
      wait_d = '0;
    end else if ((state_q == ST_ACCESS) && !bus_ack) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Wait counter and one-cycle error pulse (high during COMPLETE after a timeout).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      mem_err_q <= tmo;
    end
  end

  assign mem_err = mem_err_q;
`else
  localparam int unsigned unused_timeout = TIMEOUT;
  assign mem_err = 1'b0;
`endif

  // Next-state, freeze and bus request; freeze is gated so reset forces it low.
  always_comb begin
    state_d  = state_q;
    freeze   = 1'b0;
    bus_req  = 1'b0;
    launch   = 1'b0;
    ack_take = 1'b0;
    tmo      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rst && (mem_r_en_in || mem_w_en_in)) begin
          freeze  = 1'b1;
          launch  = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        freeze  = 1'b1;
        bus_req = 1'b1;
        if (bus_ack) begin
          ack_take = 1'b1;
          state_d  = ST_COMPLETE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          tmo     = 1'b1;
          state_d = ST_COMPLETE;
        end
`endif
      end
      ST_COMPLETE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus fields latch at launch; load data captured on ack (reads only) or on timeout.
  always_comb begin
    bus_addr_d  = bus_addr_q;
    bus_we_d    = bus_we_q;
    bus_wdata_d = bus_wdata_q;
    data_d      = data_q;
    if (launch) begin
      bus_addr_d  = word_addr;
      bus_we_d    = mem_w_en_in;
      bus_wdata_d = val_rm_in;
    end
    if (ack_take && !bus_we_q) begin
      data_d = bus_rdata;
    end else if (tmo) begin
      data_d = LOAD_ERR_DATA;
    end
  end

  // Bus driver and captured-data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_wdata_q <= '0;
      data_q      <= '0;
    end else begin
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      bus_wdata_q <= bus_wdata_d;
      data_q      <= data_d;
    end
  end

  assign bus_addr  = bus_addr_q;
  assign bus_we    = bus_we_q;
  assign bus_wdata = bus_wdata_q;

  // MEM/WB loads when not frozen; the load data only enters from COMPLETE.
  mem_wb_reg u_mem_wb (
    .clk         (clk),
    .rst_n       (rst),
    .load_i      (!freeze),
    .bubble_i    (freeze),
    .data_load_i (state_q == ST_COMPLETE),
    .wb_en_i     (wb_en_in),
    .mem_r_en_i  (mem_r_en_in),
    .dest_i      (dest_in),
    .alu_res_i   (alu_res_in),
    .mem_data_i  (data_q),
    .wb_en_o     (wb_en_out),
    .mem_r_en_o  (mem_r_en_out),
    .dest_o      (dest_out),
    .alu_res_o   (alu_res_out),
    .mem_data_o  (mem_data_out)
  );

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram with a per-instruction timeline model.
module tb_mem_stage_sram;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en_in, mem_w_en_in, wb_en_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic        bus_req, bus_we;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ack;
  logic        freeze, wb_en_out, mem_r_en_out;
  logic [3:0]  dest_out;
  logic [31:0] alu_res_out, mem_data_out;
  logic        mem_err;

  always #5 clk = ~clk;

  mem_stage_sram #(.BASE_ADDR(1024), .ADDR_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
    .dest_in(dest_in), .alu_res_in(alu_res_in), .val_rm_in(val_rm_in),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .freeze(freeze),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .dest_out(dest_out),
    .alu_res_out(alu_res_out), .mem_data_out(mem_data_out), .mem_err(mem_err)
  );

  int total = 0;
  int bad   = 0;

  // Expected MEM/WB contents
  logic        e_wb, e_mr;
  logic [3:0]  e_dest;
  logic [31:0] e_alu, e_data;

  bit          stray;
  logic [15:0] last_addr;
  logic        last_we;
  logic [31:0] last_wdata;
  int          last_freeze;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_addr(input logic [31:0] a);
    return 16'((a - 32'd1024) / 32'd4);
  endfunction

  task automatic chk_mwb();
    chk("wb_en_out", wb_en_out, e_wb);
    chk("mem_r_en_out", mem_r_en_out, e_mr);
    chk("dest_out", dest_out, e_dest);
    chk("alu_res_out", alu_res_out, e_alu);
    chk("mem_data_out", mem_data_out, e_data);
  endtask

  // One instruction held at the stage inputs until it retires.
  // delay = ack wait cycles; delay < 0 means no ack at all (timeout build).
  task automatic run_instr(input logic r, input logic w, input logic wb,
                           input logic [3:0] d, input logic [31:0] alu,
                           input logic [31:0] rm, input int delay,
                           input logic [31:0] rdata);
    bit mem;
    bit tmo;
    int acc;
    int n;
    bit f_exp;
    bit r_exp;
    mem = r | w;
    tmo = mem && (delay < 0);
    acc = !mem ? 0 : (tmo ? TMO : delay + 1);
    n   = mem ? acc + 2 : 1;
    last_freeze = 0;
    mem_r_en_in = r; mem_w_en_in = w; wb_en_in = wb;
    dest_in = d; alu_res_in = alu; val_rm_in = rm;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      f_exp = mem && (k < n - 1);
      r_exp = mem && (k >= 1) && (k <= acc);
      bus_ack = 1'b0;
      chk("freeze", freeze, f_exp);
      chk("bus_req", bus_req, r_exp);
      chk("mem_err", mem_err, tmo && (k == n - 1));
      if (freeze) last_freeze++;
      if (r_exp) begin
        chk("bus_addr", bus_addr, exp_addr(alu));
        chk("bus_we", bus_we, w);
        if (w) chk("bus_wdata", bus_wdata, rm);
        last_addr = bus_addr; last_we = bus_we; last_wdata = bus_wdata;
        if (!tmo && (k == acc)) begin
          bus_ack = 1'b1; bus_rdata = rdata;
        end
      end else if (stray) begin
        bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (f_exp) begin
        e_wb = 1'b0; e_mr = 1'b0;
      end else begin
        e_wb = wb; e_mr = r; e_dest = d; e_alu = alu;
        if (tmo) e_data = 32'hDEADBEEF;
        else if (r && !w) e_data = rdata;
      end
      chk_mwb();
    end
  endtask

  initial begin
    rst = 1'b0;
    mem_r_en_in = 0; mem_w_en_in = 0; wb_en_in = 0;
    dest_in = 0; alu_res_in = 0; val_rm_in = 0;
    bus_ack = 0; bus_rdata = 0; stray = 0;
    e_wb = 0; e_mr = 0; e_dest = 0; e_alu = 0; e_data = 0;
    last_addr = 0; last_we = 0; last_wdata = 0; last_freeze = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_mem_err", mem_err, 0);
    chk_mwb();
    rst = 1'b1;

    // Non-memory op with stray acks around it
    stray = 1;
    run_instr(0, 0, 1, 4'd3, 32'h55, 32'h0, 0, 32'h0);
    stray = 0;
    chk("nm_wb_lit", wb_en_out, 1);
    chk("nm_dest_lit", dest_out, 3);
    chk("nm_alu_lit", alu_res_out, 32'h55);

    // Load, two wait cycles
    run_instr(1, 0, 1, 4'd5, 32'd1028, 32'h0, 2, 32'hCAFE0001);
    chk("ld_addr_lit", last_addr, 16'd1);
    chk("ld_we_lit", last_we, 0);
    chk("ld_freeze_lit", last_freeze, 4);
    chk("ld_mr_lit", mem_r_en_out, 1);
    chk("ld_data_lit", mem_data_out, 32'hCAFE0001);

    // Store, immediate ack; rdata on the bus must not be captured
    run_instr(0, 1, 0, 4'd0, 32'd1032, 32'h1234, 0, 32'hBAD0BAD0);
    chk("st_addr_lit", last_addr, 16'd2);
    chk("st_we_lit", last_we, 1);
    chk("st_wdata_lit", last_wdata, 32'h1234);
    chk("st_freeze_lit", last_freeze, 2);
    chk("st_wb_lit", wb_en_out, 0);
    chk("st_data_held_lit", mem_data_out, 32'hCAFE0001);

    // Back-to-back loads, second with stray acks outside ACCESS
    run_instr(1, 0, 1, 4'd6, 32'd2048, 32'h0, 1, 32'h11112222);
    chk("b2b1_addr_lit", last_addr, 16'd256);
    stray = 1;
    run_instr(1, 0, 1, 4'd7, 32'd1424, 32'h0, 0, 32'h33334444);
    stray = 0;
    chk("b2b2_addr_lit", last_addr, 16'd100);
    chk("b2b2_data_lit", mem_data_out, 32'h33334444);

    // Non-memory op keeps load data
    run_instr(0, 0, 1, 4'd9, 32'h0000A5A5, 32'h0, 0, 32'h0);
    chk("nm2_data_held_lit", mem_data_out, 32'h33334444);

    // Address below BASE_ADDR wraps
    run_instr(1, 0, 1, 4'd1, 32'd0, 32'h0, 0, 32'h0BADF00D);
    chk("wrap_addr_lit", last_addr, 16'hFF00);

    // Read and write together: write wins, wb follows input
    run_instr(1, 1, 1, 4'd2, 32'd1036, 32'hFEED, 1, 32'h77777777);
    chk("rw_we_lit", last_we, 1);
    chk("rw_wb_lit", wb_en_out, 1);
    chk("rw_data_held_lit", mem_data_out, 32'h0BADF00D);

`ifdef MEM_TIMEOUT_EN
    run_instr(1, 0, 1, 4'd4, 32'd1040, 32'h0, -1, 32'h0);
    chk("tmo_data_lit", mem_data_out, 32'hDEADBEEF);
    chk("tmo_freeze_lit", last_freeze, TMO + 1);
`endif

    // Reset in the middle of an access
    mem_r_en_in = 1; mem_w_en_in = 0; wb_en_in = 1;
    dest_in = 4'hC; alu_res_in = 32'd1100; val_rm_in = 32'h0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_req", bus_req, 1);
    #1 rst = 1'b0;
    #1;
    chk("arst_bus_req", bus_req, 0);
    chk("arst_freeze", freeze, 0);
    chk("arst_bus_addr", bus_addr, 0);
    chk("arst_bus_we", bus_we, 0);
    chk("arst_bus_wdata", bus_wdata, 0);
    e_wb = 0; e_mr = 0; e_dest = 0; e_alu = 0; e_data = 0;
    chk_mwb();
    mem_r_en_in = 0; wb_en_in = 0; dest_in = 0; alu_res_in = 0;
    bus_ack = 1; bus_rdata = 32'h99999999;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("late_ack_req", bus_req, 0);
    @(posedge clk); #1;
    bus_ack = 0;
    chk("late_ack_freeze", freeze, 0);
    chk_mwb();

    // Recovery after reset
    run_instr(0, 0, 1, 4'hE, 32'h12345678, 32'h0, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
